gate_sweep_checker: RTL and testbench

- Hardware stimulus and response checker for the 16-bit elementary combinational gates (Not16, pass-through, increment, negate).
- Drives an exhaustive, incrementing input sweep into an external combinational DUT and compares the DUT output against an internally computed expected value.
- Counts mismatches, captures the first failing vector, and reports pass or fail at the end of the sweep.
- Sits beside the gate under test in simulation and FPGA bring-up, in place of per-gate behavioural benches.

---
 rtl/gate_check_pkg.sv | 21 ++
 rtl/gate_sweep_checker_if.sv | 30 +++
 rtl/gate_expect.sv | 26 ++
 rtl/gate_sweep_checker.sv | 93 +++++++++
 tb/tb_gate_sweep_checker.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_check_pkg.sv
// Shared encodings for the gate sweep checker: expected-function opcodes,
// sweep FSM states and the error counter ceiling.
// Latency: n/a (types and constants only). Backpressure: n/a.
package gate_check_pkg;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_PASS = 2'b01,
    OP_INC  = 2'b10,
    OP_NEG  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Control, stimulus/response and status bundle between a test controller
// (master, which also hosts the gate under test) and the sweep checker (slave).
// Latency: n/a (wires only). Backpressure: none, plain level signals.
// Ports: start/abort/op command the sweep, stim/dut_out form the gate loop,
// busy/done/pass/err_count/first_fail/fail_seen report status.
interface gate_sweep_checker_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [WIDTH-1:0] first_fail;
  logic             fail_seen;

  modport master (
    output start, abort, op, dut_out,
    input  stim, busy, done, pass, err_count, first_fail, fail_seen
  );

  modport slave (
    input  start, abort, op, dut_out,
    output stim, busy, done, pass, err_count, first_fail, fail_seen
  );
endinterface

// File: rtl/gate_expect.sv
// Reference value of an elementary 16-bit-style gate for a given opcode.
// Latency: purely combinational. Backpressure: none.
// Ports: op (expected function), a (gate input), y (expected gate output).
module gate_expect
  import gate_check_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // INC and NEG wrap naturally at WIDTH bits: INC(all ones)=0, NEG(MSB only)=MSB only.
  always_comb begin
    y = a;
    case (op)
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      OP_INC:  y = a + ONE;
      OP_NEG:  y = ~a + ONE;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps stim 0..LAST_VEC into an external combinational gate and checks its response.
// Latency: first stim 1 cycle after start; LAST_VEC+1 RUN cycles; done on the last compare edge.
// Backpressure: none; abort cancels a running sweep, start is ignored while running.
// Ports: clk, reset (async, active-high), bus (slave side of gate_sweep_checker_if).
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LAST_VEC = 2**WIDTH - 1
) (
  input logic                  clk,
  input logic                  reset,
  gate_sweep_checker_if.slave  bus
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LAST_VEC);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] stim_q;
  logic [WIDTH-1:0] first_fail_q;
  logic [15:0]      err_q;
  logic             fail_seen_q;
  logic [WIDTH-1:0] expect_val;
  logic             mismatch;
  logic             at_last;
  logic             launch;

  gate_expect #(.WIDTH(WIDTH)) u_expect (
    .op (op_q),
    .a  (stim_q),
    .y  (expect_val)
  );

  // No DUT pipeline: the response to stim_q is valid in the same cycle.
  assign mismatch = (bus.dut_out != expect_val);
  assign at_last  = (stim_q == LAST);
  // start is honoured from IDLE and DONE alike; in RUN it is ignored.
  assign launch   = bus.start && (state_q != ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        // abort beats the final-vector transition
        if (bus.abort)    state_d = ST_IDLE;
        else if (at_last) state_d = ST_DONE;
      end
      ST_DONE: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= OP_NOT;
      stim_q       <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else if (launch) begin
      op_q         <= op_e'(bus.op);
      stim_q       <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else if (state_q == ST_RUN && !bus.abort) begin
      // An aborted cycle leaves the bookkeeping exactly as it was for inspection.
      if (mismatch) begin
        if (err_q != ERR_MAX) err_q <= err_q + 16'd1;
        if (!fail_seen_q) begin
          first_fail_q <= stim_q;
          fail_seen_q  <= 1'b1;
        end
      end
      if (!at_last) stim_q <= stim_q + ONE;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_q == 16'd0);
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_seen  = fail_seen_q;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a short-sweep instance under randomized faults and
// aborts, plus three full 16-bit instances (INC, NEG, always-wrong gate) in parallel.
// Latency/backpressure: n/a (simulation only).
module tb_gate_sweep_checker;
  localparam int N = 256;  // vectors in a short sweep (LAST_VEC = 255)

  logic clk = 1'b0;
  logic rst_s, rst_f;
  initial forever #5 clk = ~clk;

  gate_sweep_checker_if #(.WIDTH(16)) sif ();
  gate_sweep_checker_if #(.WIDTH(16)) fa ();
  gate_sweep_checker_if #(.WIDTH(16)) fb ();
  gate_sweep_checker_if #(.WIDTH(16)) fc ();

  gate_sweep_checker #(.WIDTH(16), .LAST_VEC(255))   u_s (.clk(clk), .reset(rst_s), .bus(sif));
  gate_sweep_checker #(.WIDTH(16), .LAST_VEC(65535)) u_a (.clk(clk), .reset(rst_f), .bus(fa));
  gate_sweep_checker #(.WIDTH(16), .LAST_VEC(65535)) u_b (.clk(clk), .reset(rst_f), .bus(fb));
  gate_sweep_checker #(.WIDTH(16), .LAST_VEC(65535)) u_c (.clk(clk), .reset(rst_f), .bus(fc));

  int checks = 0;
  int passes = 0;

  // Gate-under-test configuration for the short instance.
  int          gop    = 0;
  logic [15:0] stk0   = 16'h0000;
  logic [15:0] stk1   = 16'h0000;
  logic [15:0] flip_m = 16'h0000;
  logic [15:0] flip_v = 16'h0000;

  // Model: pre[i] = mismatches among vectors 0..i-1; firstm = first mismatching vector.
  int pre [0:N];
  int firstm = 0;
  int sk = 0;   // cycles since the sweep's start edge (0 = never started / reset)
  int ab = 0;   // value of sk on the cycle abort was taken, 0 if none
  int busy_cnt = 0;

  function automatic logic [15:0] ideal_v(input int g, input logic [15:0] v);
    int x;
    x = int'(v);
    case (g)
      0:       x = 65535 - x;
      1:       x = x;
      2:       x = (x + 1) % 65536;
      default: x = (65536 - x) % 65536;
    endcase
    return 16'(x);
  endfunction

  assign sif.dut_out = ((ideal_v(gop, sif.stim) & ~stk0) | stk1) ^ ((sif.stim == flip_v) ? flip_m : 16'h0000);
  assign fa.dut_out  = ideal_v(2, fa.stim);
  assign fb.dut_out  = ideal_v(3, fb.stim);
  assign fc.dut_out  = ideal_v(1, fc.stim) ^ 16'hFFFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic setup_model(input int op);
    logic [15:0] dv;
    bit m, seen;
    seen = 0;
    firstm = 0;
    pre[0] = 0;
    for (int v = 0; v < N; v++) begin
      dv = ((ideal_v(gop, 16'(v)) & ~stk0) | stk1) ^ ((16'(v) == flip_v) ? flip_m : 16'h0000);
      m = (dv != ideal_v(op, 16'(v)));
      pre[v+1] = pre[v] + int'(m);
      if (m && !seen) begin
        seen = 1;
        firstm = v;
      end
    end
  endtask

  // Sweep progress as seen by the model.
  always @(posedge clk) begin
    if (rst_s) begin
      sk <= 0;
      ab <= 0;
    end else if (sif.start && (sk == 0 || ab != 0 || sk > N)) begin
      sk <= 1;
      ab <= 0;
    end else if (sk > 0) begin
      if (sif.abort && ab == 0 && sk <= N) ab <= sk;
      sk <= sk + 1;
    end
  end

  // Per-cycle comparison of the short instance against the model.
  always begin
    int e_s, e_e;
    bit e_b, e_d;
    @(posedge clk);
    #1;
    if (sk == 0) begin
      e_b = 0; e_d = 0; e_s = 0; e_e = 0;
    end else if (ab != 0 && sk > ab) begin
      e_b = 0; e_d = 0; e_s = ab - 1; e_e = pre[ab-1];
    end else if (sk <= N) begin
      e_b = 1; e_d = 0; e_s = sk - 1; e_e = pre[sk-1];
    end else begin
      e_b = 0; e_d = 1; e_s = N - 1; e_e = pre[N];
    end
    if (sif.busy) busy_cnt++;
    chk("cyc busy", sif.busy, e_b);
    chk("cyc done", sif.done, e_d);
    chk("cyc stim", sif.stim, e_s);
    chk("cyc err_count", sif.err_count, e_e);
    chk("cyc fail_seen", sif.fail_seen, e_e > 0);
    chk("cyc first_fail", sif.first_fail, (e_e > 0) ? firstm : 0);
    chk("cyc pass", sif.pass, e_d && e_e == 0);
  end

  // av = stim value at which abort is applied, -1 for a complete sweep.
  task automatic run_short(input int op, input int g, input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] fm, input logic [15:0] fv, input int av, input bit abort_with_start);
    @(negedge clk);
    gop = g; stk0 = s0; stk1 = s1; flip_m = fm; flip_v = fv;
    sif.op = 2'(op);
    setup_model(op);
    busy_cnt = 0;
    sif.start = 1'b1;
    sif.abort = abort_with_start;
    @(negedge clk);
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk("restart stim", sif.stim, 0);
    chk("restart err_count", sif.err_count, 0);
    chk("restart fail_seen", sif.fail_seen, 0);
    chk("restart busy", sif.busy, 1);
    if (av >= 0) begin
      repeat (av) @(negedge clk);
      sif.abort = 1'b1;
      @(negedge clk);
      sif.abort = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (N/2) @(negedge clk);
      sif.start = 1'b1;           // ignored while running
      @(negedge clk);
      sif.start = 1'b0;
      repeat (N/2 + 3) @(negedge clk);
      sif.abort = 1'b1;           // no effect once done
      @(negedge clk);
      sif.abort = 1'b0;
    end
  endtask

  task automatic short_tests();
    chk("reset done", sif.done, 0);
    chk("reset stim", sif.stim, 0);
    // Correct NOT gate.
    run_short(0, 0, 16'h0, 16'h0, 16'h0, 16'h0, -1, 0);
    chk("not busy cycles", busy_cnt, 256);
    chk("not done", sif.done, 1);
    chk("not pass", sif.pass, 1);
    chk("not err", sif.err_count, 0);
    chk("not first_fail", sif.first_fail, 0);
    chk("not stim", sif.stim, 255);
    // Output bit 3 stuck at 0.
    run_short(0, 0, 16'h0008, 16'h0, 16'h0, 16'h0, -1, 0);
    chk("stuck err", sif.err_count, 128);
    chk("stuck first_fail", sif.first_fail, 0);
    chk("stuck fail_seen", sif.fail_seen, 1);
    chk("stuck pass", sif.pass, 0);
    // Same fault, aborted at stim 0x40.
    run_short(0, 0, 16'h0008, 16'h0, 16'h0, 16'h0, 64, 0);
    chk("abort busy", sif.busy, 0);
    chk("abort done", sif.done, 0);
    chk("abort err", sif.err_count, 32);
    chk("abort first_fail", sif.first_fail, 0);
    chk("abort stim", sif.stim, 64);
    // Single flipped vector in a PASS gate, started with abort also high.
    run_short(1, 1, 16'h0, 16'h0, 16'h0100, 16'h0077, -1, 1);
    chk("flip err", sif.err_count, 1);
    chk("flip first_fail", sif.first_fail, 16'h0077);
    // Asynchronous reset between edges mid-sweep.
    @(negedge clk);
    gop = 1; stk0 = 0; stk1 = 0; flip_m = 0; flip_v = 0;
    sif.op = 2'd1;
    setup_model(1);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_s = 1'b1;
    #1;
    chk("async rst stim", sif.stim, 0);
    chk("async rst busy", sif.busy, 0);
    chk("async rst done", sif.done, 0);
    chk("async rst pass", sif.pass, 0);
    chk("async rst err", sif.err_count, 0);
    chk("async rst first_fail", sif.first_fail, 0);
    chk("async rst fail_seen", sif.fail_seen, 0);
    @(negedge clk);
    rst_s = 1'b0;
    // Randomized sweeps.
    for (int r = 0; r < 12; r++) begin
      int op, g, kind, av;
      logic [15:0] s0, s1, fm, fv;
      op = int'($urandom_range(0, 3));
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : op;
      s0 = 16'h0; s1 = 16'h0; fm = 16'h0; fv = 16'h0;
      kind = int'($urandom_range(0, 3));
      case (kind)
        1: s0 = 16'h0001 << $urandom_range(0, 15);
        2: s1 = 16'h0001 << $urandom_range(0, 15);
        3: begin
          fm = 16'($urandom_range(1, 65535));
          fv = 16'($urandom_range(0, N - 1));
        end
        default: ;
      endcase
      av = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_short(op, g, s0, s1, fm, fv, av, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic full_tests();
    bit spot_done;
    spot_done = 0;
    @(negedge clk);
    fa.op = 2'd2; fb.op = 2'd3; fc.op = 2'd1;
    fa.start = 1'b1; fb.start = 1'b1; fc.start = 1'b1;
    @(negedge clk);
    fa.start = 1'b0; fb.start = 1'b0; fc.start = 1'b0;
    for (int i = 0; i < 66000; i++) begin
      @(negedge clk);
      if (fb.stim == 16'h8001 && !spot_done) begin
        spot_done = 1;
        chk("neg 8000 err", fb.err_count, 0);
      end
      if (fa.done && fb.done && fc.done) break;
    end
    chk("full sweeps done", {fa.done, fb.done, fc.done}, 3'b111);
    chk("inc pass", fa.pass, 1);
    chk("inc err", fa.err_count, 0);
    chk("inc stim", fa.stim, 16'hFFFF);
    chk("neg pass", fb.pass, 1);
    chk("neg err", fb.err_count, 0);
    chk("sat err", fc.err_count, 16'hFFFF);
    chk("sat first_fail", fc.first_fail, 0);
    chk("sat fail_seen", fc.fail_seen, 1);
    chk("sat pass", fc.pass, 0);
    fc.start = 1'b1;
    @(negedge clk);
    fc.start = 1'b0;
    chk("sat restart err", fc.err_count, 0);
    chk("sat restart stim", fc.stim, 0);
    chk("sat restart fail_seen", fc.fail_seen, 0);
    @(negedge clk);
    chk("sat rerun err", fc.err_count, 1);
    chk("sat rerun stim", fc.stim, 1);
    fc.abort = 1'b1;
    @(negedge clk);
    fc.abort = 1'b0;
    chk("sat abort busy", fc.busy, 0);
    chk("sat abort done", fc.done, 0);
    chk("sat abort err", fc.err_count, 1);
  endtask

  initial begin
    sif.start = 0; sif.abort = 0; sif.op = 0;
    fa.start = 0;  fa.abort = 0;  fa.op = 0;
    fb.start = 0;  fb.abort = 0;  fb.op = 0;
    fc.start = 0;  fc.abort = 0;  fc.op = 0;
    rst_s = 1'b1;
    rst_f = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    rst_f = 1'b0;
    fork
      short_tests();
      full_tests();
    join
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
